wb_sevenseg_multi: RTL and testbench

//  Wishbone-slave seven-segment display controller for NDIGITS hex digits. Supersedes the single-register

---
 rtl/sevenseg_pkg.sv | 38 +++
 rtl/sevenseg_hex_decode.sv | 11 +
 rtl/wb_sevenseg_multi.sv | 169 ++++++++++++++++
 tb/tb_wb_sevenseg_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multi-digit Wishbone seven-segment controller:
// register map, CTRL field offsets, bus state encoding, hex font and byte-lane merge helper.
package sevenseg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_BLINK  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_LSB    = 0;
  localparam int CTRL_BLINK_LSB = 8;
  localparam int CTRL_LZB_BIT   = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  // Replace the bytes of i_old selected by i_sel with the matching bytes of i_new
  function automatic logic [31:0] byte_merge(input logic [31:0] i_old,
                                             input logic [31:0] i_new,
                                             input logic [3:0]  i_sel);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) begin
      v[8*b +: 8] = i_sel[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
import sevenseg_pkg::*;

module sevenseg_hex_decode (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_FONT[i_nibble];

endmodule

// File: rtl/wb_sevenseg_multi.sv
// Wishbone slave driving NDIGITS hex digits with per-digit enable, blink and
// leading-zero blanking. Register file, blink timer and bus handshake live here;
// the per-digit font lookup is in sevenseg_hex_decode.
//
//  state    | meaning
//  BUS_IDLE | no request accepted last cycle, ack low
//  BUS_ACK  | request accepted last cycle, ack high while cyc held
import sevenseg_pkg::*;

module wb_sevenseg_multi #(
  parameter int                 NDIGITS   = 6,
  parameter int                 BLINK_W   = 24,
  parameter logic [BLINK_W-1:0] BLINK_RST = 24'd12_500_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [29:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  input  logic [3:0]             i_wb_sel,
  output logic                   o_wb_ack,
  output logic                   o_wb_stall,
  output logic [31:0]            o_wb_data,
  input  logic                   i_alt_sel,
  input  logic [31:0]            i_alt_data,
  output logic [7*NDIGITS-1:0]   o_segments
);

  localparam int DW = 4 * NDIGITS;

  logic [DW-1:0]          r_data;
  logic [NDIGITS-1:0]     r_en;
  logic [NDIGITS-1:0]     r_blink;
  logic                   r_lzb;
  logic [BLINK_W-1:0]     r_div;
  logic [BLINK_W-1:0]     r_cnt;
  logic                   r_phase;
  logic [7*NDIGITS-1:0]   r_segments;
  logic [31:0]            r_rdata;
  bus_state_t             r_state;

  bus_state_t             w_state_next;
  logic                   w_accept;
  logic                   w_wr;
  logic [1:0]             w_addr;
  logic [31:0]            w_rd_mux;
  logic [DW-1:0]          w_src;
  logic [NDIGITS-1:0]     w_lz;
  logic [7*NDIGITS-1:0]   w_dec;
  logic                   w_unused;

  assign w_unused   = ^{i_wb_addr[29:2], i_alt_data};
  assign w_addr     = i_wb_addr[1:0];
  assign o_wb_stall = ~i_reset_n;
  assign w_accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign w_wr       = w_accept & i_wb_we;

  // Bus handshake state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= BUS_IDLE;
    else            r_state <= w_state_next;
  end

  // Ack one cycle after every accepted request
  always_comb begin
    w_state_next = BUS_IDLE;
    if (w_accept) w_state_next = BUS_ACK;
  end

  assign o_wb_ack  = (r_state == BUS_ACK) & i_wb_cyc;
  assign o_wb_data = o_wb_ack ? r_rdata : 32'd0;

  // Readback mux, zero-extending implemented fields
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_addr)
      REG_DATA:   w_rd_mux = 32'(r_data);
      REG_CTRL: begin
        w_rd_mux[CTRL_EN_LSB    +: NDIGITS] = r_en;
        w_rd_mux[CTRL_BLINK_LSB +: NDIGITS] = r_blink;
        w_rd_mux[CTRL_LZB_BIT]              = r_lzb;
      end
      REG_BLINK:  w_rd_mux = 32'(r_div);
      default:    w_rd_mux = {30'd0, i_alt_sel, r_phase};
    endcase
  end

  // Capture read data on accept; it reflects the register before a same-cycle write
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                r_rdata <= 32'd0;
    else if (w_accept && !i_wb_we) r_rdata <= w_rd_mux;
    else                           r_rdata <= 32'd0;
  end

  // Register file with byte-lane writes; unimplemented bits are dropped
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_data  <= '0;
      r_en    <= '1;
      r_blink <= '0;
      r_lzb   <= 1'b0;
      r_div   <= BLINK_RST;
    end else if (w_wr) begin
      case (w_addr)
        REG_DATA:  r_data <= DW'(byte_merge(32'(r_data), i_wb_data, i_wb_sel));
        REG_CTRL: begin
          if (i_wb_sel[0]) r_en    <= i_wb_data[CTRL_EN_LSB    +: NDIGITS];
          if (i_wb_sel[1]) r_blink <= i_wb_data[CTRL_BLINK_LSB +: NDIGITS];
          if (i_wb_sel[2]) r_lzb   <= i_wb_data[CTRL_LZB_BIT];
        end
        REG_BLINK: r_div <= BLINK_W'(byte_merge(32'(r_div), i_wb_data, i_wb_sel));
        default: ;
      endcase
    end
  end

  // Blink timer; a BLINK_DIV write restarts it and takes priority over terminal count
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr && (w_addr == REG_BLINK)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_div) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + BLINK_W'(1);
    end
  end

  assign w_src = i_alt_sel ? i_alt_data[DW-1:0] : r_data;

  // Leading-zero flags scanned from the top digit down; digit 0 always shown
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    w_lz       = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (w_src[4*k +: 4] == 4'd0);
      w_lz[k]    = r_lzb & zero_above & (k != 0);
    end
  end

  for (genvar k = 0; k < NDIGITS; k++) begin : g_dec
    sevenseg_hex_decode u_dec (
      .i_nibble (w_src[4*k +: 4]),
      .o_seg    (w_dec[7*k +: 7])
    );
  end

  // Registered display stage applying enable, blanking and blink
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_segments <= '1;
    end else begin
      for (int k = 0; k < NDIGITS; k++) begin
        r_segments[7*k +: 7] <= (r_en[k] & ~w_lz[k] & ~(r_blink[k] & r_phase))
                                ? w_dec[7*k +: 7] : SEG_BLANK;
      end
    end
  end

  assign o_segments = r_segments;

endmodule

// File: tb/tb_wb_sevenseg_multi.sv
// Directed bench for wb_sevenseg_multi with the default six digits.
module tb_wb_sevenseg_multi;

  localparam int ND = 6;

  localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, SF = 7'h0E, SB = 7'h7F;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cyc, stb, we;
  logic [29:0]     addr;
  logic [31:0]     wdata;
  logic [3:0]      sel;
  logic            ack, stall;
  logic [31:0]     rdata;
  logic            alt_sel;
  logic [31:0]     alt_data;
  logic [7*ND-1:0] segs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_sevenseg_multi dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_addr  (addr),
    .i_wb_data  (wdata),
    .i_wb_sel   (sel),
    .o_wb_ack   (ack),
    .o_wb_stall (stall),
    .o_wb_data  (rdata),
    .i_alt_sel  (alt_sel),
    .i_alt_data (alt_data),
    .o_segments (segs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7*ND-1:0] seg6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Single transfer: called at posedge+1, returns at posedge+1 two edges later
  task automatic wb_xfer(input string tag, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; addr = {28'd0, a}; wdata = d; sel = s;
    chk({tag, " ack before edge"}, ack, 1'b0);
    @(posedge clk); #1;
    stb = 1'b0;
    chk({tag, " ack"}, ack, 1'b1);
    rd = rdata;
    @(posedge clk); #1;
    chk({tag, " ack single"}, ack, 1'b0);
    cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; alt_sel = 1'b0; alt_data = '0;

    // Reset and release
    @(posedge clk); @(posedge clk); #1;
    chk("reset stall", stall, 1'b1);
    chk("reset ack", ack, 1'b0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset segs blank", segs, {7*ND{1'b1}});
    reset_n = 1'b1;
    #1;
    chk("stall released", stall, 1'b0);
    chk("first cycle blank", segs, {7*ND{1'b1}});
    @(posedge clk); #1;
    chk("zeros after reset", segs, seg6(S0, S0, S0, S0, S0, S0));

    wb_xfer("rd ctrl reset", 1'b0, 2'd1, 32'd0, 4'hF, rd);
    chk("ctrl reset value", rd, 32'h0000_003F);
    wb_xfer("rd div reset", 1'b0, 2'd2, 32'd0, 4'hF, rd);
    chk("blink_div reset value", rd, 32'd12_500_000);

    // Partial byte-lane write
    wb_xfer("wr data lo", 1'b1, 2'd0, 32'h0012_3456, 4'b0011, rd);
    chk("segs partial data", segs, seg6(S0, S0, S3, S4, S5, S6));
    wb_xfer("rd data", 1'b0, 2'd0, 32'd0, 4'hF, rd);
    chk("data readback", rd, 32'h0000_3456);

    // Leading-zero blanking
    wb_xfer("wr ctrl lzb", 1'b1, 2'd1, 32'h0001_003F, 4'hF, rd);
    wb_xfer("wr data 42", 1'b1, 2'd0, 32'h0000_0042, 4'hF, rd);
    chk("segs lzb 42", segs, seg6(SB, SB, SB, SB, S4, S2));

    // Blink on digit 0 with half period of 4 cycles
    wb_xfer("wr ctrl blink", 1'b1, 2'd1, 32'h0000_013F, 4'hF, rd);
    wb_xfer("wr div 3", 1'b1, 2'd2, 32'h0000_0003, 4'hF, rd);
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      chk($sformatf("blink n=%0d", n), segs,
          seg6(S0, S0, S0, S0, S4, ((((n - 1) / 4) % 2) == 1) ? SB : S2));
    end
    wb_xfer("rd status blink", 1'b0, 2'd3, 32'd0, 4'hF, rd);
    chk("status phase high", rd, 32'h0000_0001);

    // Alternate source with LZB, including all-zero value
    wb_xfer("wr ctrl lzb2", 1'b1, 2'd1, 32'h0001_003F, 4'hF, rd);
    alt_sel = 1'b1; alt_data = 32'h0000_0F00;
    @(posedge clk); #1;
    chk("alt f00 lzb", segs, seg6(SB, SB, SB, SF, S0, S0));
    alt_data = 32'h0000_0000;
    @(posedge clk); #1;
    chk("alt zero lzb", segs, seg6(SB, SB, SB, SB, SB, S0));
    wb_xfer("rd status alt", 1'b0, 2'd3, 32'd0, 4'hF, rd);
    chk("status alt bit", rd & 32'hFFFF_FFFE, 32'h0000_0002);
    alt_sel = 1'b0;

    // Unimplemented bits drop on full writes; STATUS ignores writes
    wb_xfer("wr data ff", 1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer("rd data ff", 1'b0, 2'd0, 32'd0, 4'hF, rd);
    chk("data width mask", rd, 32'h00FF_FFFF);
    wb_xfer("wr ctrl ff", 1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer("rd ctrl ff", 1'b0, 2'd1, 32'd0, 4'hF, rd);
    chk("ctrl width mask", rd, 32'h0001_3F3F);
    wb_xfer("wr div ff", 1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer("rd div ff", 1'b0, 2'd2, 32'd0, 4'hF, rd);
    chk("div width mask", rd, 32'h00FF_FFFF);
    wb_xfer("wr status", 1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer("rd status", 1'b0, 2'd3, 32'd0, 4'hF, rd);
    chk("status write ignored", rd, 32'h0000_0000);

    // Pipelined W,R,R
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd0; wdata = 32'h0000_00A5; sel = 4'hF;
    @(posedge clk); #1;
    chk("pipe ack w", ack, 1'b1);
    we = 1'b0;
    @(posedge clk); #1;
    chk("pipe ack r1", ack, 1'b1);
    chk("pipe data r1", rdata, 32'h0000_00A5);
    @(posedge clk); #1;
    chk("pipe ack r2", ack, 1'b1);
    chk("pipe data r2", rdata, 32'h0000_00A5);
    stb = 1'b0;
    @(posedge clk); #1;
    chk("pipe ack end", ack, 1'b0);
    cyc = 1'b0;

    // cyc drop suppresses ack but write commits
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd0; wdata = 32'h0000_0077; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    chk("cyc drop no ack", ack, 1'b0);
    @(posedge clk); #1;
    wb_xfer("rd after drop", 1'b0, 2'd0, 32'd0, 4'hF, rd);
    chk("write after drop", rd, 32'h0000_0077);

    // Reset in the middle of a write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd0; wdata = 32'h0000_0011; sel = 4'hF;
    reset_n = 1'b0;
    #1;
    chk("mid reset stall", stall, 1'b1);
    @(posedge clk); #1;
    chk("mid reset ack", ack, 1'b0);
    chk("mid reset segs", segs, {7*ND{1'b1}});
    reset_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    wb_xfer("rd data post reset", 1'b0, 2'd0, 32'd0, 4'hF, rd);
    chk("no commit in reset", rd, 32'h0000_0000);
    wb_xfer("rd ctrl post reset", 1'b0, 2'd1, 32'd0, 4'hF, rd);
    chk("ctrl after reset", rd, 32'h0000_003F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
